ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave endpoint on one MI port of the generated AHB bus.
- Consumes the slave-side request struct, select and global ready from the bus, and returns the response struct.
- Backed by an internal word-organised register array, with programmable wait states and a two-cycle ERROR response.
- Serves as the standard on-chip memory and scratchpad target for bus bring-up and verification.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the window; haddr below it is out of range.
- DEPTH_WORDS, 256, number of 32-bit words; power of 2, 16..4096.
- WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase; 0..15.

Ports:
- hclk  in  1  bus clock; all state on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select from the bus arbiter, e.g. hsel_slave_N.
- hready_in  in  1  global HREADY; the address phase is sampled only when it is 1.
- slv_in  in  mas_send_type (78)  haddr[31:0], hwdata[31:0], htrans[1:0], hburst[2:0], hsize[2:0], hwrite, hprot[3:0], hmastlock.
- slv_out  out  slv_send_type (34)  hreadyout, hrdata[31:0], hresp (0 = OKAY, 1 = ERROR).

Behaviour:
- Reset: state=IDLE, hreadyout=1, hresp=0, hrdata=0, all address-phase registers cleared. Array contents are not reset.
- A reset asserted mid-transfer aborts it; a pending write is not committed.
- Address-phase accept condition: hsel & hready_in & htrans[1] (NONSEQ or SEQ).
  - On accept, register haddr, hwrite, hsize and an error flag.
  - Error flag = haddr < ADDR_BASE, or word index (haddr-ADDR_BASE)>>2 >= DEPTH_WORDS, or hsize > 3'b010.
- htrans IDLE/BUSY, or hsel=0: no access; the next data phase is zero-wait OKAY.
- States:
  - IDLE: no transfer pending.
    - Accept with error -> ERR1.
    - Accept with WAIT_STATES>0 -> WAIT, load the counter with WAIT_STATES.
    - Accept with WAIT_STATES=0 -> DATA.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 1 -> DATA.
  - DATA: hreadyout=1, hresp=0.
    - Write: commit slv_in.hwdata to the array at the rising edge that ends this cycle.
    - Read: hrdata = array[addr_q], combinational from the registered index; 0 outside read DATA.
    - A new address phase may be accepted in the same cycle (pipelined). Next state is per the IDLE rules, or IDLE if nothing is accepted.
  - ERR1: hreadyout=0, hresp=1. Never writes. Address phases are ignored (hready_in is 0). Next -> ERR2.
  - ERR2: hreadyout=1, hresp=1. A new address phase may be accepted, then next state per the IDLE rules.
- Latency:
  - Read/write data phase = 1+WAIT_STATES cycles.
  - Error = exactly 2 cycles.
  - Back-to-back zero-wait transfers sustain 1 transfer per cycle.
- Read-after-write to the same word in consecutive transfers returns the new data, because the write commits before the read data phase.
- hburst, hprot and hmastlock are ignored; every beat is an independent access.
- Address decode wraps only within [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).

Optional Feature:
- Macro AHB_SRAM_BYTE_STROBE_EN.
- Defined:
  - hsize 0 writes update only byte lane haddr[1:0].
  - hsize 1 writes update only halfword lane haddr[1].
  - Misaligned halfword (haddr[0]=1) or misaligned word (haddr[1:0]!=0) -> ERROR.
  - Reads always return the full word.
- Undefined:
  - Any hsize other than 3'b010 -> ERROR.
  - haddr[1:0] is ignored for word accesses.

Decomposition:
- AHB_package holds:
  - mas_send_type and slv_send_type (existing).
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR and HSIZE_BYTE/HALF/WORD constants.
  - ahb_sram_state_e enum {IDLE, WAIT, DATA, ERR1, ERR2}.
- Sub-module ahb_sram_array:
  - DEPTH_WORDS x 32 storage.
  - Write port with 4-bit byte enable; enables are tied to 4'hF when the macro is undefined.
  - Combinational read port.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF to 0x10, then read 0x10 back-to-back -> read data phase hreadyout=1, hrdata=32'hDEAD_BEEF, hresp=0, no stall cycles.
- WAIT_STATES=3: read 0x04 -> hreadyout low for exactly 3 cycles, high on the 4th with the data; the following NONSEQ is accepted in that 4th cycle.
- Read 0x400 with DEPTH_WORDS=256 -> cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1; a following write to 0x0 is not corrupted.
- htrans=BUSY with hsel=1, then IDLE with hsel=0 -> hreadyout=1, hresp=0, array unchanged.
- AHB_SRAM_BYTE_STROBE_EN: word write 0x1122_3344 at 0x8, then byte write 0xAA at 0x9 -> read 0x8 returns 32'h1122_AA44. Undefined build: the same byte write -> 2-cycle ERROR and the word stays 0x1122_3344.
- hreset pulsed during WAIT of a write -> outputs return to hreadyout=1/hresp=0/hrdata=0 immediately and the target word is unchanged.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// AHB-Lite bus types and constants shared by the bus fabric and the SRAM slave.
// Also holds the SRAM slave state encoding and its byte-lane helper.
package AHB_package;

  typedef struct packed {
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [3:0]  hprot;
    logic        hmastlock;
  } mas_send_type;

  typedef struct packed {
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;
  } slv_send_type;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} ahb_sram_state_e;

  // Byte enables for a write of the given size at the given byte lane.
  function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_array.sv
// Word-organised storage for the AHB SRAM slave: byte-enabled write port,
// combinational read port, contents not reset.
module ahb_sram_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          hclk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and a two-cycle ERROR response.
// Define AHB_SRAM_BYTE_STROBE_EN to allow byte and halfword writes.
//
//   state | meaning
//   IDLE  | no transfer pending
//   WAIT  | OKAY data phase stalled, counter running
//   DATA  | OKAY data phase completing, write commits / read data valid
//   ERR1  | first ERROR cycle, hreadyout low
//   ERR2  | second ERROR cycle, hreadyout high
module ahb_sram_slave
  import AHB_package::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic         hclk,
  input  logic         hreset,
  input  logic         hsel,
  input  logic         hready_in,
  input  mas_send_type slv_in,
  output slv_send_type slv_out
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

  ahb_sram_state_e state;
  logic            hreadyout_q;
  logic            hresp_q;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [3:0]      cnt_q;

  logic [31:0] offset;
  logic [31:0] rd_data;
  logic        accept;
  logic        addr_err;
  logic        size_err;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic        unused_bits;

  assign offset   = slv_in.haddr - ADDR_BASE;
  assign accept   = hsel && hready_in &&
                    (slv_in.htrans == HTRANS_NONSEQ || slv_in.htrans == HTRANS_SEQ);
  assign addr_err = (slv_in.haddr < ADDR_BASE) || (offset[31:2] >= DEPTH_L);

  // Burst type, protection and lock carry no meaning for a flat memory.
  assign unused_bits = ^{offset[1:0], slv_in.hburst, slv_in.hprot, slv_in.hmastlock};

`ifdef AHB_SRAM_BYTE_STROBE_EN
  logic [1:0] lane_q;
  logic [2:0] size_q;

  assign size_err = (slv_in.hsize > HSIZE_WORD) ||
                    (slv_in.hsize == HSIZE_HALF && slv_in.haddr[0]) ||
                    (slv_in.hsize == HSIZE_WORD && slv_in.haddr[1:0] != 2'b00);
  assign wr_be    = lane_enable(size_q, lane_q);
`else
  assign size_err = (slv_in.hsize != HSIZE_WORD);
  assign wr_be    = 4'hF;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state       <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      write_q     <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= 4'd0;
`ifdef AHB_SRAM_BYTE_STROBE_EN
      lane_q      <= 2'b00;
      size_q      <= 3'b000;
`endif
    end else begin
      case (state)
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state       <= DATA;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ERR1: begin
          state       <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with hreadyout high, so each can take a new address phase.
          if (accept) begin
            addr_q  <= offset[AW+1:2];
            write_q <= slv_in.hwrite;
`ifdef AHB_SRAM_BYTE_STROBE_EN
            lane_q  <= slv_in.haddr[1:0];
            size_q  <= slv_in.hsize;
`endif
            if (addr_err || size_err) begin
              state       <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state       <= WAIT;
              cnt_q       <= WS_L;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state       <= DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state       <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign wr_en = (state == DATA) && write_q;

  ahb_sram_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .hclk  (hclk),
    .we    (wr_en),
    .be    (wr_be),
    .addr  (addr_q),
    .wdata (slv_in.hwdata),
    .rdata (rd_data)
  );

  always_comb begin
    slv_out           = '0;
    slv_out.hreadyout = hreadyout_q;
    slv_out.hresp     = hresp_q;
    slv_out.hrdata    = (state == DATA && !write_q) ? rd_data : 32'h0;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states) driven by a pipelined
// AHB master, checked every cycle against a transaction-level response/memory model.
module tb_ahb_sram_slave;
  import AHB_package::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } item_t;

  typedef struct {
    logic       rdy;
    logic       resp;
    logic       rd;
    logic       wr;
    int         idx;
    logic [3:0] mask;
  } cyc_t;

  logic         hclk   = 1'b0;
  logic         hreset = 1'b1;
  logic         hsel      [2];
  logic         hready_in [2];
  mas_send_type req       [2];
  slv_send_type rsp       [2];

  int total = 0;
  int bad   = 0;

  logic [31:0]  mdl_mem [2][DEPTH];
  logic [3:0]   mdl_vld [2][DEPTH];
  item_t        txq [$];
  slv_send_type obs [$];

  always #5 hclk = ~hclk;

  assign hready_in[0] = rsp[0].hreadyout;
  assign hready_in[1] = rsp[1].hreadyout;

  ahb_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .hready_in(hready_in[0]),
    .slv_in(req[0]), .slv_out(rsp[0]));

  ahb_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .hready_in(hready_in[1]),
    .slv_in(req[1]), .slv_out(rsp[1]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // ---------------- reference model (window/size rules, byte lanes) ----------------
  function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
    longint off;
    logic   e;
    off = {32'd0, a} - {32'd0, BASE};
    e   = (off < 0) || ((off >>> 2) >= DEPTH);
`ifdef AHB_SRAM_BYTE_STROBE_EN
    e = e || (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
`else
    e = e || (s != 3'd2);
`endif
    return e;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SRAM_BYTE_STROBE_EN
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
`endif
    return 4'hF;
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic monitor(input int k);
    cyc_t q [$];
    cyc_t e;
    cyc_t idle_c;
    cyc_t c;
    logic [31:0] m;
    logic [31:0] a;
    idle_c = '{rdy: 1'b1, resp: 1'b0, rd: 1'b0, wr: 1'b0, idx: 0, mask: 4'h0};
    forever begin
      @(negedge hclk);
      if (hreset) q.delete();
      e = (q.size() > 0) ? q[0] : idle_c;
      chk($sformatf("dut%0d hreadyout", k), 32'(rsp[k].hreadyout), 32'(e.rdy));
      chk($sformatf("dut%0d hresp", k), 32'(rsp[k].hresp), 32'(e.resp));
      if (e.rd) begin
        m = expand(mdl_vld[k][e.idx]);
        if (m != 32'h0)
          chk($sformatf("dut%0d hrdata word %0d", k, e.idx), rsp[k].hrdata & m, mdl_mem[k][e.idx] & m);
      end else begin
        chk($sformatf("dut%0d hrdata outside read", k), rsp[k].hrdata, 32'h0);
      end
      @(posedge hclk);
      if (hreset) begin
        q.delete();
        continue;
      end
      e = (q.size() > 0) ? q.pop_front() : idle_c;
      if (e.wr) begin
        for (int b = 0; b < 4; b++)
          if (e.mask[b]) mdl_mem[k][e.idx][8*b +: 8] = req[k].hwdata[8*b +: 8];
        mdl_vld[k][e.idx] = mdl_vld[k][e.idx] | e.mask;
      end
      if (e.rdy && hsel[k] && req[k].htrans[1]) begin
        a = req[k].haddr;
        if (is_err(a, req[k].hsize)) begin
          q.push_back('{rdy: 1'b0, resp: 1'b1, rd: 1'b0, wr: 1'b0, idx: 0, mask: 4'h0});
          q.push_back('{rdy: 1'b1, resp: 1'b1, rd: 1'b0, wr: 1'b0, idx: 0, mask: 4'h0});
        end else begin
          repeat (ws_of(k)) q.push_back('{rdy: 1'b0, resp: 1'b0, rd: 1'b0, wr: 1'b0, idx: 0, mask: 4'h0});
          c.rdy  = 1'b1;
          c.resp = 1'b0;
          c.rd   = !req[k].hwrite;
          c.wr   = req[k].hwrite;
          c.idx  = int'((a - BASE) >> 2);
          c.mask = byte_mask(a, req[k].hsize);
          q.push_back(c);
        end
      end
    end
  endtask

  // ---------------- pipelined master ----------------
  function automatic item_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    item_t it;
    it.sel = sel; it.trans = tr; it.wr = wr; it.addr = addr; it.size = size; it.data = data;
    return it;
  endfunction

  function automatic void wr_w(input logic [31:0] addr, input logic [31:0] data);
    txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, addr, HSIZE_WORD, data));
  endfunction

  function automatic void rd_w(input logic [31:0] addr);
    txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, addr, HSIZE_WORD, 32'h0));
  endfunction

  function automatic slv_send_type obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return '0;
  endfunction

  task automatic run(input int k);
    item_t a;
    item_t d;
    item_t idle_i;
    logic  prev_rdy;
    int    guard;
    idle_i   = mk(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    a        = idle_i;
    d        = idle_i;
    prev_rdy = 1'b1;
    guard    = 0;
    obs.delete();
    txq.push_back(idle_i);
    txq.push_back(idle_i);
    forever begin
      @(negedge hclk);
      if (prev_rdy) begin
        if (txq.size() == 0) break;
        d = (a.sel && a.trans[1]) ? a : idle_i;
        a = txq.pop_front();
      end
      hsel[k]           = a.sel;
      req[k].haddr      = a.addr;
      req[k].htrans     = a.trans;
      req[k].hwrite     = a.wr;
      req[k].hsize      = a.size;
      req[k].hburst     = 3'($urandom);
      req[k].hprot      = 4'($urandom);
      req[k].hmastlock  = 1'($urandom);
      req[k].hwdata     = d.wr ? d.data : 32'h0;
      obs.push_back(rsp[k]);
      prev_rdy = rsp[k].hreadyout;
      guard++;
      if (guard > 5000) begin
        total++;
        bad++;
        $display("FAIL run%0d: hreadyout stuck low, %0d cycles, limit 5000", k, guard);
        break;
      end
    end
    hsel[k]       = 1'b0;
    req[k].htrans = HTRANS_IDLE;
  endtask

  function automatic item_t rand_item();
    item_t it;
    int    p;
    it.size = ($urandom_range(0, 99) < 70) ? HSIZE_WORD : 3'($urandom_range(0, 4));
    p = $urandom_range(0, 99);
    if (p < 85)      it.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    else if (p < 95) it.addr = 32'h400 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    else             it.addr = 32'hFFFF_FF00 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 99) < 20) it.addr[1:0] = 2'($urandom);
    else if (it.size == HSIZE_BYTE) it.addr[1:0] = 2'($urandom);
    else if (it.size == HSIZE_HALF) it.addr[1] = 1'($urandom);
    it.trans = ($urandom_range(0, 99) < 75) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    it.sel   = ($urandom_range(0, 99) < 90);
    it.wr    = 1'($urandom);
    it.data  = $urandom;
    return it;
  endfunction

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog: time limit reached, got %0t expected under 5000000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 1'b0;
      req[k]  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mdl_mem[k][i] = 32'h0;
        mdl_vld[k][i] = 4'h0;
      end
    end
    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (2) @(negedge hclk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset dut%0d hreadyout", k), 32'(rsp[k].hreadyout), 32'd1);
      chk($sformatf("reset dut%0d hresp", k), 32'(rsp[k].hresp), 32'd0);
      chk($sformatf("reset dut%0d hrdata", k), rsp[k].hrdata, 32'h0);
    end
    hreset = 1'b0;

    // zero-wait write then back-to-back read
    wr_w(32'h10, 32'hDEAD_BEEF);
    rd_w(32'h10);
    run(0);
    for (int i = 0; i < 3; i++) chk($sformatf("ws0 b2b cycle %0d hreadyout", i), 32'(obs_at(i).hreadyout), 32'd1);
    chk("ws0 raw hrdata", obs_at(2).hrdata, 32'hDEAD_BEEF);
    chk("ws0 raw hresp", 32'(obs_at(2).hresp), 32'd0);

    // three wait states, follow-on NONSEQ accepted in the completing cycle
    wr_w(32'h04, 32'hCAFE_0004);
    rd_w(32'h04);
    rd_w(32'h08);
    run(1);
    for (int i = 1; i < 4; i++) chk($sformatf("ws3 write wait %0d", i), 32'(obs_at(i).hreadyout), 32'd0);
    chk("ws3 write done", 32'(obs_at(4).hreadyout), 32'd1);
    for (int i = 5; i < 8; i++) chk($sformatf("ws3 read wait %0d", i), 32'(obs_at(i).hreadyout), 32'd0);
    chk("ws3 read done", 32'(obs_at(8).hreadyout), 32'd1);
    chk("ws3 read data", obs_at(8).hrdata, 32'hCAFE_0004);
    chk("ws3 next accepted", 32'(obs_at(9).hreadyout), 32'd0);

    // out-of-range read: two-cycle error, then a clean write/read
    rd_w(32'h400);
    wr_w(32'h0, 32'h55AA_0000);
    rd_w(32'h0);
    run(0);
    chk("err c1 hreadyout", 32'(obs_at(1).hreadyout), 32'd0);
    chk("err c1 hresp", 32'(obs_at(1).hresp), 32'd1);
    chk("err c2 hreadyout", 32'(obs_at(2).hreadyout), 32'd1);
    chk("err c2 hresp", 32'(obs_at(2).hresp), 32'd1);
    chk("after err hresp", 32'(obs_at(3).hresp), 32'd0);
    chk("after err data", obs_at(4).hrdata, 32'h55AA_0000);

    // BUSY and unselected IDLE leave memory untouched
    wr_w(32'h20, 32'h1234_5678);
    txq.push_back(mk(1'b1, HTRANS_BUSY, 1'b1, 32'h20, HSIZE_WORD, 32'hFFFF_FFFF));
    txq.push_back(mk(1'b0, HTRANS_IDLE, 1'b1, 32'h20, HSIZE_WORD, 32'hFFFF_FFFF));
    rd_w(32'h20);
    run(0);
    for (int i = 0; i < 5; i++) chk($sformatf("busy/idle cycle %0d hreadyout", i), 32'(obs_at(i).hreadyout), 32'd1);
    chk("busy/idle data", obs_at(4).hrdata, 32'h1234_5678);

    // byte write into a word
    wr_w(32'h08, 32'h1122_3344);
    txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, 32'h09, HSIZE_BYTE, 32'h0000_AA00));
    rd_w(32'h08);
    run(0);
`ifdef AHB_SRAM_BYTE_STROBE_EN
    chk("byte write hresp", 32'(obs_at(2).hresp), 32'd0);
    chk("byte merge data", obs_at(3).hrdata, 32'h1122_AA44);
`else
    chk("byte err c1 hresp", 32'(obs_at(2).hresp), 32'd1);
    chk("byte err c1 hreadyout", 32'(obs_at(2).hreadyout), 32'd0);
    chk("byte err c2 hreadyout", 32'(obs_at(3).hreadyout), 32'd1);
    chk("byte rejected data", obs_at(4).hrdata, 32'h1122_3344);
`endif

    // reset during the wait phase of a write
    wr_w(32'h30, 32'h1111_2222);
    run(1);
    @(negedge hclk);
    hsel[1] = 1'b1; req[1].htrans = HTRANS_NONSEQ; req[1].haddr = 32'h30;
    req[1].hwrite = 1'b1; req[1].hsize = HSIZE_WORD;
    @(negedge hclk);
    hsel[1] = 1'b0; req[1].htrans = HTRANS_IDLE; req[1].hwdata = 32'hFFFF_FFFF;
    chk("pre-reset in wait", 32'(rsp[1].hreadyout), 32'd0);
    #2 hreset = 1'b1;
    #1;
    chk("mid-reset hreadyout", 32'(rsp[1].hreadyout), 32'd1);
    chk("mid-reset hresp", 32'(rsp[1].hresp), 32'd0);
    chk("mid-reset hrdata", rsp[1].hrdata, 32'h0);
    @(negedge hclk);
    #2 hreset = 1'b0;
    rd_w(32'h30);
    run(1);
    chk("reset aborted write", obs_at(4).hrdata, 32'h1111_2222);

    // randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 200; i++) txq.push_back(rand_item());
      run(k);
    end

    repeat (3) @(negedge hclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
